// File: rtl/slc3_trace_pkg.sv
// Shared types and width helpers for the SLC-3 trace-capture unit.
package slc3_trace_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StCapture = 2'd1,
      StPost    = 2'd2,
      StDone    = 2'd3
   } trace_state_t;

   function automatic int unsigned ptr_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/trace_ring.sv
// Circular sample buffer: unreset storage, wrapping pointers, fill level, fall-through read.
module trace_ring
   import slc3_trace_pkg::*;
#(
   parameter int unsigned Width = 64,
   parameter int unsigned Depth = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clear_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [Width-1:0]         wdata_i,
   output logic [Width-1:0]         rdata_o,
   output logic [$clog2(Depth):0]   level_o
);

   localparam int unsigned PtrW = ptr_w(Depth);
   localparam int unsigned LvlW = PtrW + 1;
   localparam logic [LvlW-1:0] Full = LvlW'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic [LvlW-1:0]  lvl_q, lvl_d;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      lvl_d = lvl_q;
      if (clear_i) begin
         wr_d  = '0;
         rd_d  = '0;
         lvl_d = '0;
      end else if (push_i) begin
         wr_d = wr_q + PtrW'(1);
         // A push into a full ring discards the oldest entry.
         if (lvl_q == Full) rd_d = rd_q + PtrW'(1);
         else               lvl_d = lvl_q + LvlW'(1);
      end else if (pop_i && lvl_q != '0) begin
         rd_d  = rd_q + PtrW'(1);
         lvl_d = lvl_q - LvlW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         lvl_q <= lvl_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !clear_i) mem_q[wr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_q];
   assign level_o = lvl_q;

endmodule

// File: rtl/slc3_trace_capture.sv
// Trace capture for the SLC-3 datapath: stop-on-full or triggered ring capture with halt request.
module slc3_trace_capture
   import slc3_trace_pkg::*;
#(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned TRIG_CH  = 0
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic                        arm,
   input  logic                        mode,
   input  logic [WIDTH-1:0]            trig_value,
   input  logic [$clog2(DEPTH)-1:0]    post_count,
   input  logic                        sample,
   input  logic [CHANNELS*WIDTH-1:0]   ch_data,
   input  logic                        rd_en,
   output logic [CHANNELS*WIDTH-1:0]   rd_data,
   output logic                        rd_valid,
   output logic [$clog2(DEPTH):0]      level,
   output logic [1:0]                  state,
   output logic                        halt_req
);

   localparam int unsigned PtrW = ptr_w(DEPTH);
   localparam int unsigned LvlW = PtrW + 1;
   localparam logic [LvlW-1:0] AlmostFull = LvlW'(DEPTH - 1);

   trace_state_t     state_q, state_d;
   logic             mode_q, mode_d;
   logic [WIDTH-1:0] trig_q, trig_d;
   logic [PtrW-1:0]  post_q, post_d, remain_q, remain_d;
   logic             clear, push, pop, trig_hit;
   logic [CHANNELS*WIDTH-1:0] ring_rdata;

   assign trig_hit = (ch_data[TRIG_CH*WIDTH +: WIDTH] == trig_q);

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      trig_d   = trig_q;
      post_d   = post_q;
      remain_d = remain_q;
      clear    = 1'b0;
      push     = 1'b0;
      pop      = 1'b0;
      // arm overrides any sample or pop in the same cycle.
      if (arm) begin
         clear   = 1'b1;
         state_d = StCapture;
         mode_d  = mode;
         trig_d  = trig_value;
         post_d  = post_count;
      end else begin
         unique case (state_q)
            StIdle: ;
            StCapture: begin
               if (sample) begin
                  push = 1'b1;
                  if (!mode_q) begin
                     if (level == AlmostFull) state_d = StDone;
                  end else if (trig_hit) begin
                     remain_d = post_q;
                     state_d  = (post_q == '0) ? StDone : StPost;
                  end
               end
            end
            StPost: begin
               if (sample) begin
                  push     = 1'b1;
                  remain_d = remain_q - PtrW'(1);
                  if (remain_q == PtrW'(1)) state_d = StDone;
               end
            end
            StDone: pop = rd_en;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= StIdle;
         mode_q   <= 1'b0;
         trig_q   <= '0;
         post_q   <= '0;
         remain_q <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         trig_q   <= trig_d;
         post_q   <= post_d;
         remain_q <= remain_d;
      end
   end

   trace_ring #(
      .Width (CHANNELS * WIDTH),
      .Depth (DEPTH)
   ) u_ring (
      .clk_i   (Clk),
      .rst_i   (Reset),
      .clear_i (clear),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (ch_data),
      .rdata_o (ring_rdata),
      .level_o (level)
   );

   assign rd_valid = (state_q == StDone) && (level != '0);
   assign rd_data  = rd_valid ? ring_rdata : '0;
   assign state    = state_q;
   assign halt_req = (state_q == StDone);

endmodule

// File: tb/tb_slc3_trace_capture.sv
// Directed bench for slc3_trace_capture: vector table plus hand-written capture sequences.
module tb_slc3_trace_capture;

   logic        Clk = 1'b0;
   logic        Reset, arm, mode, sample, rd_en;
   logic [15:0] trig_value;
   logic [3:0]  post_count;
   logic [63:0] ch_data, rd_data;
   logic        rd_valid, halt_req;
   logic [4:0]  level;
   logic [1:0]  state;

   int n_cmp = 0;
   int n_err = 0;

   slc3_trace_capture dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .arm        (arm),
      .mode       (mode),
      .trig_value (trig_value),
      .post_count (post_count),
      .sample     (sample),
      .ch_data    (ch_data),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .level      (level),
      .state      (state),
      .halt_req   (halt_req)
   );

   always #5 Clk = ~Clk;

   function automatic logic [63:0] mk(input logic [15:0] pc);
      return {pc + 16'h0003, pc + 16'h0002, pc + 16'h0001, pc};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_st(input string name, input int lvl, input int st, input logic hlt,
                           input logic vld);
      check({name, " level"}, 64'(level), 64'(lvl));
      check({name, " state"}, 64'(state), 64'(st));
      check({name, " halt"}, 64'(halt_req), 64'(hlt));
      check({name, " valid"}, 64'(rd_valid), 64'(vld));
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
      arm    = 1'b0;
      sample = 1'b0;
      rd_en  = 1'b0;
   endtask

   task automatic do_arm(input logic m, input logic [15:0] tv, input logic [3:0] pc_n);
      arm = 1'b1; mode = m; trig_value = tv; post_count = pc_n;
      step();
   endtask

   task automatic do_sample(input logic [15:0] pc);
      sample = 1'b1; ch_data = mk(pc);
      step();
   endtask

   task automatic do_pop();
      rd_en = 1'b1;
      step();
   endtask

   typedef struct {
      logic        arm, mode, sample, rd_en;
      logic [15:0] trig, pc;
      logic [3:0]  post;
      int          lvl, st;
      logic        hlt, vld;
      logic [63:0] rd;
   } vec_t;

   vec_t vt[9];

   initial begin
      // Immediate trigger and simultaneous-event vectors; expectations hold after the edge.
      vt[0] = '{1, 1, 0, 0, 16'h4001, 16'h0000, 4'd0, 0, 1, 0, 0, 64'h0};
      vt[1] = '{0, 0, 1, 0, 16'h0000, 16'h4000, 4'd0, 1, 1, 0, 0, 64'h0};
      vt[2] = '{0, 0, 0, 1, 16'h0000, 16'h0000, 4'd0, 1, 1, 0, 0, 64'h0};
      vt[3] = '{0, 0, 1, 0, 16'h0000, 16'h4001, 4'd0, 2, 3, 1, 1, mk(16'h4000)};
      vt[4] = '{0, 0, 1, 0, 16'h0000, 16'h4002, 4'd0, 2, 3, 1, 1, mk(16'h4000)};
      vt[5] = '{0, 0, 0, 1, 16'h0000, 16'h0000, 4'd0, 1, 3, 1, 1, mk(16'h4001)};
      vt[6] = '{1, 1, 1, 0, 16'h4001, 16'h4001, 4'd0, 0, 1, 0, 0, 64'h0};
      vt[7] = '{0, 0, 1, 0, 16'h0000, 16'h5000, 4'd0, 1, 1, 0, 0, 64'h0};
      vt[8] = '{1, 0, 0, 1, 16'h0000, 16'h0000, 4'd0, 0, 1, 0, 0, 64'h0};

      Reset = 1'b1; arm = 0; mode = 0; sample = 0; rd_en = 0;
      trig_value = '0; post_count = '0; ch_data = '0;
      repeat (2) @(posedge Clk);
      #1;
      check_st("reset", 0, 0, 0, 0);
      check("reset rd_data", rd_data, 64'h0);
      Reset = 1'b0;

      // Stop-on-full
      do_arm(0, 16'h0, 4'd0);
      check_st("sof armed", 0, 1, 0, 0);
      for (int i = 0; i < 20; i++) begin
         do_sample(16'h3000 + 16'(i));
         if (i == 14) check_st("sof 15th", 15, 1, 0, 0);
         if (i == 15) check_st("sof 16th", 16, 3, 1, 1);
      end
      check_st("sof extra samples", 16, 3, 1, 1);
      for (int k = 0; k < 16; k++) begin
         check("sof pop data", rd_data, mk(16'h3000 + 16'(k)));
         do_pop();
      end
      check_st("sof drained", 0, 3, 1, 0);
      check("sof drained rd_data", rd_data, 64'h0);
      do_pop();
      check_st("pop at level 0", 0, 3, 1, 0);

      // Ring with trigger
      do_arm(1, 16'h3014, 4'd3);
      for (int i = 0; i <= 30; i++) begin
         do_sample(16'h3000 + 16'(i));
         if (i == 15) check_st("ring full", 16, 1, 0, 0);
         if (i == 20) check_st("ring trig", 16, 2, 0, 0);
         if (i == 22) check_st("ring post", 16, 2, 0, 0);
         if (i == 23) check_st("ring done", 16, 3, 1, 1);
      end
      for (int k = 0; k < 16; k++) begin
         check("ring pop data", rd_data, mk(16'h3008 + 16'(k)));
         do_pop();
      end
      check_st("ring drained", 0, 3, 1, 0);

      // Table vectors
      foreach (vt[i]) begin
         arm = vt[i].arm; mode = vt[i].mode; trig_value = vt[i].trig;
         post_count = vt[i].post; sample = vt[i].sample; rd_en = vt[i].rd_en;
         ch_data = mk(vt[i].pc);
         step();
         check_st($sformatf("vec%0d", i), vt[i].lvl, vt[i].st, vt[i].hlt, vt[i].vld);
         check($sformatf("vec%0d rd_data", i), rd_data, vt[i].rd);
      end

      // Asynchronous reset in the middle of POST
      do_arm(1, 16'h6002, 4'd5);
      for (int i = 0; i < 4; i++) do_sample(16'h6000 + 16'(i));
      check_st("pre-reset post", 4, 2, 0, 0);
      #2 Reset = 1'b1;
      #1;
      check_st("async reset", 0, 0, 0, 0);
      check("async reset rd_data", rd_data, 64'h0);
      @(posedge Clk);
      #1 Reset = 1'b0;
      do_arm(0, 16'h0, 4'd0);
      do_sample(16'h7000);
      check_st("after reset", 1, 1, 0, 0);

      // Re-arm from DONE with entries unread
      do_arm(0, 16'h0, 4'd0);
      for (int i = 0; i < 16; i++) do_sample(16'h8000 + 16'(i));
      for (int k = 0; k < 11; k++) do_pop();
      check_st("5 unread", 5, 3, 1, 1);
      check("5 unread data", rd_data, mk(16'h800B));
      do_arm(1, 16'h0, 4'd0);
      check_st("rearm", 0, 1, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
